// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between instruction fetch (IFU) and load/store (LSU).
// One transaction in flight; LSU has priority, bounded by a burst counter so IFU cannot starve.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int MAX_LS_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req,
  input  logic [ADDR_W-1:0]   ifu_addr,
  input  logic                ifu_flush,
  output logic                ifu_gnt,
  output logic                ifu_rvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_gnt,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;
  localparam logic [3:0] MAX_CNT = 4'(MAX_LS_BURST);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                drop_q, drop_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   ifu_hold_q, ifu_hold_d;
  logic [DATA_W-1:0]   lsu_hold_q, lsu_hold_d;
  logic                ifu_wins;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IFU;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
      ifu_hold_q <= '0;
      lsu_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      rdata_q    <= rdata_d;
      ifu_hold_q <= ifu_hold_d;
      lsu_hold_q <= lsu_hold_d;
    end
  end

  // IFU takes the port when LSU is absent or has used up its burst allowance.
  assign ifu_wins = ifu_req && !ifu_flush && (!lsu_req || (cnt_q == MAX_CNT));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    rdata_d    = rdata_q;
    ifu_hold_d = ifu_hold_q;
    lsu_hold_d = lsu_hold_q;
    ifu_gnt    = 1'b0;
    lsu_gnt    = 1'b0;
    ifu_rvalid = 1'b0;
    lsu_rvalid = 1'b0;

    // Handshakes are suppressed in the reset cycle since the state they imply is discarded.
    if (!rst) begin
      if (ifu_flush && (owner_q == OWN_IFU) && (state_q != S_IDLE)) begin
        drop_d = 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (ifu_wins) begin
            ifu_gnt = 1'b1;
            addr_d  = ifu_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
            owner_d = OWN_IFU;
            drop_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_REQ;
          end else if (lsu_req) begin
            lsu_gnt = 1'b1;
            addr_d  = lsu_addr;
            we_d    = lsu_we;
            wdata_d = lsu_wdata;
            wmask_d = lsu_wmask;
            owner_d = OWN_LSU;
            drop_d  = 1'b0;
            if (!ifu_req) begin
              cnt_d = '0;
            end else if (cnt_q != MAX_CNT) begin
              cnt_d = cnt_q + 4'd1;
            end
            state_d = S_REQ;
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            if (mem_rvalid) begin
              rdata_d = mem_rdata;
              state_d = S_RESP;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            rdata_d = mem_rdata;
            state_d = S_RESP;
          end
        end
        S_RESP: begin
          drop_d  = 1'b0;
          state_d = S_IDLE;
          if (owner_q == OWN_LSU) begin
            lsu_rvalid = 1'b1;
            lsu_hold_d = rdata_q;
          end else if (!drop_q && !ifu_flush) begin
            ifu_rvalid = 1'b1;
            ifu_hold_d = rdata_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Read data is visible during the pulse and held afterwards without extra latency.
  assign ifu_rdata = ifu_rvalid ? rdata_q : ifu_hold_q;
  assign lsu_rdata = lsu_rvalid ? rdata_q : lsu_hold_q;

  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change 1ns after posedge, checks at negedge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req, ifu_flush, ifu_gnt, ifu_rvalid;
  logic [63:0] ifu_addr, ifu_rdata;
  logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
  logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, busy;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_LS_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_flush(ifu_flush),
    .ifu_gnt(ifu_gnt), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Drives the bus side of a granted transaction: gnt in REQ, rvalid in WAIT, then steps past RESP.
  task automatic serve(input logic [63:0] rd);
    mem_gnt = 1'b1;
    nxt();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
    nxt();
    mem_rvalid = 1'b0; mem_rdata = '0;
    nxt();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nxt(); nxt();
    @(negedge clk);
    checks++; if ({ifu_gnt, ifu_rvalid, lsu_gnt, lsu_rvalid, mem_req, mem_we, busy} !== 7'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=0000000", {ifu_gnt, ifu_rvalid, lsu_gnt, lsu_rvalid, mem_req, mem_we, busy}); end
    checks++; if ({mem_addr, mem_wdata, mem_wmask} !== 136'b0) begin errors++; $display("FAIL reset_bus got=%h/%h/%h exp=0", mem_addr, mem_wdata, mem_wmask); end
    checks++; if ({ifu_rdata, lsu_rdata} !== 128'b0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0", ifu_rdata, lsu_rdata); end
    rst = 1'b0;
    nxt();
  endtask

  task automatic test_ifu_alone();
    ifu_req = 1'b1; ifu_addr = 64'h8000_0000;
    @(negedge clk);
    checks++; if ({ifu_gnt, lsu_gnt, busy} !== 3'b100) begin errors++; $display("FAIL ifu_alone_gnt got=%b exp=100", {ifu_gnt, lsu_gnt, busy}); end
    nxt();
    ifu_req = 1'b0; ifu_addr = '0; mem_gnt = 1'b1;
    @(negedge clk);
    checks++; if ({mem_req, mem_we, busy} !== 3'b101) begin errors++; $display("FAIL ifu_alone_req got=%b exp=101", {mem_req, mem_we, busy}); end
    checks++; if (mem_addr !== 64'h8000_0000) begin errors++; $display("FAIL ifu_alone_addr got=%h exp=80000000", mem_addr); end
    nxt();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h13;
    @(negedge clk);
    checks++; if ({mem_req, ifu_rvalid} !== 2'b00) begin errors++; $display("FAIL ifu_alone_wait got=%b exp=00", {mem_req, ifu_rvalid}); end
    nxt();
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    checks++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 64'h13) begin errors++; $display("FAIL ifu_alone_resp got=%b/%h exp=1/13", ifu_rvalid, ifu_rdata); end
    nxt();
    @(negedge clk);
    checks++; if ({busy, ifu_rvalid} !== 2'b00 || ifu_rdata !== 64'h13) begin errors++; $display("FAIL ifu_alone_after got=%b/%h exp=00/13", {busy, ifu_rvalid}, ifu_rdata); end
    nxt();
  endtask

  task automatic test_simultaneous();
    ifu_req = 1'b1; ifu_addr = 64'h8000_0040;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_1000;
    @(negedge clk);
    checks++; if ({lsu_gnt, ifu_gnt} !== 2'b10) begin errors++; $display("FAIL simul_first got=%b exp=10", {lsu_gnt, ifu_gnt}); end
    nxt();
    lsu_req = 1'b0; lsu_addr = '0; mem_gnt = 1'b1;
    @(negedge clk);
    checks++; if (mem_addr !== 64'h8000_1000 || ifu_gnt !== 1'b0) begin errors++; $display("FAIL simul_addr got=%h/%b exp=80001000/0", mem_addr, ifu_gnt); end
    nxt();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hAA;
    nxt();
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    checks++; if ({lsu_rvalid, ifu_gnt} !== 2'b10 || lsu_rdata !== 64'hAA) begin errors++; $display("FAIL simul_lsu_resp got=%b/%h exp=10/aa", {lsu_rvalid, ifu_gnt}, lsu_rdata); end
    nxt();
    @(negedge clk);
    checks++; if ({ifu_gnt, lsu_rvalid} !== 2'b10) begin errors++; $display("FAIL simul_ifu_next got=%b exp=10", {ifu_gnt, lsu_rvalid}); end
    nxt();
    ifu_req = 1'b0;
    serve(64'h11);
  endtask

  task automatic test_starvation();
    logic exp_ifu;
    int   lsu_seen;
    lsu_seen = 0;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_3000;
    ifu_req = 1'b1; ifu_addr = 64'h8000_0080;
    for (int i = 0; i < 6; i++) begin
      exp_ifu = (i == 4);
      @(negedge clk);
      if (lsu_gnt === 1'b1 && i < 4) lsu_seen++;
      checks++; if ({ifu_gnt, lsu_gnt} !== {exp_ifu, ~exp_ifu}) begin errors++; $display("FAIL starve_grant%0d got=%b exp=%b", i, {ifu_gnt, lsu_gnt}, {exp_ifu, ~exp_ifu}); end
      nxt();
      if (i == 4) ifu_req = 1'b0;
      if (i == 5) lsu_req = 1'b0;
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h100 + 64'(i);
      nxt();
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      nxt();
    end
    checks++; if (lsu_seen !== 4) begin errors++; $display("FAIL starve_burst got=%0d exp=4", lsu_seen); end
    checks++; if (ifu_rdata !== 64'h104) begin errors++; $display("FAIL starve_ifu_data got=%h exp=104", ifu_rdata); end
  endtask

  task automatic test_store();
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 64'h8000_2000;
    lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
    @(negedge clk);
    checks++; if (lsu_gnt !== 1'b1) begin errors++; $display("FAIL store_gnt got=%b exp=1", lsu_gnt); end
    nxt();
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    mem_gnt = 1'b1;
    @(negedge clk);
    checks++; if ({mem_req, mem_we} !== 2'b11 || mem_wmask !== 8'h0F) begin errors++; $display("FAIL store_req got=%b/%h exp=11/0f", {mem_req, mem_we}, mem_wmask); end
    checks++; if (mem_wdata !== 64'hDEAD_BEEF || mem_addr !== 64'h8000_2000) begin errors++; $display("FAIL store_data got=%h/%h exp=deadbeef/80002000", mem_wdata, mem_addr); end
    nxt();
    mem_gnt = 1'b0; ifu_flush = 1'b1;
    nxt();
    ifu_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = '0;
    nxt();
    mem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if ({lsu_rvalid, ifu_rvalid} !== 2'b10) begin errors++; $display("FAIL store_ack got=%b exp=10", {lsu_rvalid, ifu_rvalid}); end
    nxt();
  endtask

  task automatic test_flush_idle();
    ifu_req = 1'b1; ifu_flush = 1'b1; ifu_addr = 64'h8000_0400;
    @(negedge clk);
    checks++; if ({ifu_gnt, busy} !== 2'b00) begin errors++; $display("FAIL flush_idle_block got=%b exp=00", {ifu_gnt, busy}); end
    nxt();
    ifu_flush = 1'b0;
    @(negedge clk);
    checks++; if (ifu_gnt !== 1'b1) begin errors++; $display("FAIL flush_idle_retry got=%b exp=1", ifu_gnt); end
    nxt();
    ifu_req = 1'b0;
    serve(64'h22);
  endtask

  task automatic test_flush_wait();
    ifu_req = 1'b1; ifu_addr = 64'h8000_0100;
    @(negedge clk);
    checks++; if (ifu_gnt !== 1'b1) begin errors++; $display("FAIL flush_wait_gnt got=%b exp=1", ifu_gnt); end
    nxt();
    ifu_req = 1'b0; mem_gnt = 1'b1;
    nxt();
    mem_gnt = 1'b0; ifu_flush = 1'b1;
    nxt();
    ifu_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hFFFF;
    nxt();
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    checks++; if ({ifu_rvalid, busy} !== 2'b01 || ifu_rdata !== 64'h22) begin errors++; $display("FAIL flush_wait_drop got=%b/%h exp=01/22", {ifu_rvalid, busy}, ifu_rdata); end
    nxt();
    ifu_req = 1'b1; ifu_addr = 64'h8000_0200;
    @(negedge clk);
    checks++; if (ifu_gnt !== 1'b1) begin errors++; $display("FAIL flush_next_gnt got=%b exp=1", ifu_gnt); end
    nxt();
    ifu_req = 1'b0; mem_gnt = 1'b1;
    nxt();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h55;
    nxt();
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    checks++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 64'h55) begin errors++; $display("FAIL flush_next_resp got=%b/%h exp=1/55", ifu_rvalid, ifu_rdata); end
    nxt();
  endtask

  task automatic test_fast_bus();
    ifu_req = 1'b1; ifu_addr = 64'h8000_0300;
    @(negedge clk);
    checks++; if (ifu_gnt !== 1'b1) begin errors++; $display("FAIL fast_gnt got=%b exp=1", ifu_gnt); end
    nxt();
    ifu_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h77;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fast_req got=%b exp=1", mem_req); end
    nxt();
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    checks++; if ({ifu_rvalid, busy, mem_req} !== 3'b110 || ifu_rdata !== 64'h77) begin errors++; $display("FAIL fast_resp got=%b/%h exp=110/77", {ifu_rvalid, busy, mem_req}, ifu_rdata); end
    nxt();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fast_idle got=%b exp=0", busy); end
    nxt();
  endtask

  task automatic test_reset_mid();
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 64'h8000_2000;
    lsu_wdata = 64'h1234_5678; lsu_wmask = 8'hFF;
    @(negedge clk);
    checks++; if (lsu_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt got=%b exp=1", lsu_gnt); end
    nxt();
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    mem_gnt = 1'b1;
    nxt();
    mem_gnt = 1'b0; rst = 1'b1;
    nxt();
    @(negedge clk);
    checks++; if ({ifu_gnt, ifu_rvalid, lsu_gnt, lsu_rvalid, mem_req, mem_we, busy} !== 7'b0) begin errors++; $display("FAIL rstmid_ctrl got=%b exp=0000000", {ifu_gnt, ifu_rvalid, lsu_gnt, lsu_rvalid, mem_req, mem_we, busy}); end
    checks++; if ({mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata} !== 264'b0) begin errors++; $display("FAIL rstmid_data got=%h/%h/%h exp=0", mem_addr, mem_wdata, mem_wmask); end
    rst = 1'b0;
    nxt();
    mem_rvalid = 1'b1; mem_rdata = 64'h99;
    nxt();
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    checks++; if ({lsu_rvalid, busy} !== 2'b00 || lsu_rdata !== 64'h0) begin errors++; $display("FAIL rstmid_late got=%b/%h exp=00/0", {lsu_rvalid, busy}, lsu_rdata); end
    nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ifu_req = 1'b0; ifu_addr = '0; ifu_flush = 1'b0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    test_reset();
    test_ifu_alone();
    test_simultaneous();
    test_starvation();
    test_store();
    test_flush_idle();
    test_flush_wait();
    test_fast_bus();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
